cfu_reorder_buffer: RTL and testbench
=====================================

Name: cfu_reorder_buffer

Overview:
- Sits between the issuing core and any CFU that accepts out-of-order responses.
- Allocates req_id tags for core requests and forwards each request to the CFU.
- Captures CFU responses by resp_id and returns them to the core strictly in issue order.
- Lets reordering CFUs sit behind an in-order core without core-side tracking.

Parameters:
- CFU_FUNCTION_ID_W, 16, function id width (passed through).
- CFU_REQ_INPUTS, 2, request operands.
- CFU_REQ_DATA_W, 32, request operand width.
- CFU_RESP_DATA_W, 32, response data width (one output).
- CFU_ERROR_ID_W, 32, error id width.
- CFU_REQ_RESP_ID_W, 3, tag width; DEPTH = 2**CFU_REQ_RESP_ID_W outstanding entries.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- clock_en  in  1  global advance enable
- core_req_valid  in  1  core request valid
- core_req_ready  out  1  request accepted
- core_req_function_id  in  CFU_FUNCTION_ID_W  function id
- core_req_data  in  CFU_REQ_INPUTS*CFU_REQ_DATA_W  operands, operand 0 in LSBs
- cfu_req_valid  out  1  request to CFU
- cfu_req_ready  in  1  CFU accepts request
- cfu_req_function_id  out  CFU_FUNCTION_ID_W  passthrough
- cfu_req_id  out  CFU_REQ_RESP_ID_W  allocated tag
- cfu_req_data  out  CFU_REQ_INPUTS*CFU_REQ_DATA_W  passthrough
- cfu_resp_valid  in  1  CFU response valid
- cfu_resp_ready  out  1  response accepted
- cfu_resp_id  in  CFU_REQ_RESP_ID_W  response tag
- cfu_resp_data  in  CFU_RESP_DATA_W  response data
- cfu_resp_ok  in  1  response ok
- cfu_resp_error_id  in  CFU_ERROR_ID_W  error detail
- core_resp_valid  out  1  in-order response valid
- core_resp_ready  in  1  core accepts response
- core_resp_data  out  CFU_RESP_DATA_W  data
- core_resp_ok  out  1  ok
- core_resp_error_id  out  CFU_ERROR_ID_W  error detail
- protocol_error  out  1  sticky: illegal CFU response seen

Behaviour:
- Interface fixed: one clock; reset is synchronous and active-high; ports named clock and reset.
- State:
  - head and tail pointers, each CFU_REQ_RESP_ID_W+1 bits.
  - per-slot alloc[] and filled[] bits.
  - per-slot data/ok/error registers.
- Pointer rules:
  - empty = head==tail.
  - full = low bits equal and MSBs differ, i.e. DEPTH entries outstanding.
  - Both pointers wrap modulo 2*DEPTH.
- Reset values:
  - head=tail=0; alloc=filled=0; protocol_error=0.
  - Slot payload registers are not reset.
  - While reset is high, cfu_req_valid, core_req_ready, core_resp_valid and cfu_resp_ready are all 0.
- Issue path (combinational, zero latency):
  - cfu_req_valid = clock_en & core_req_valid & !full.
  - core_req_ready = clock_en & cfu_req_ready & !full.
  - cfu_req_id = tail[ID_W-1:0]; function_id and data pass straight through.
  - On cfu_req_valid & cfu_req_ready: alloc[tail]<=1 and tail++.
- Capture path:
  - cfu_resp_ready = clock_en; the buffer never backpressures the CFU, since slots are pre-reserved.
  - On handshake to a slot with alloc=1 and filled=0: store data/ok/error and set filled.
  - Response to a slot with alloc=0 or filled=1: discard it, set protocol_error (sticky until reset), leave state unchanged.
- Retire path:
  - core_resp_valid = clock_en & !empty & filled[head].
  - Payload is driven from slot[head].
  - On core_resp_valid & core_resp_ready: clear alloc[head] and filled[head], head++.
  - Latency from capture to core_resp_valid is 1 cycle, registered.
- Simultaneous events:
  - Issue, capture and retire can all occur in the same cycle.
  - Issue while full is blocked even if retire happens that cycle, so there is no ready-on-retire path.
  - A retire frees its slot for issue in the next cycle.
- clock_en=0: no state changes; all valid/ready outputs are 0.
- Reset mid-operation: all outstanding entries are dropped. Late CFU responses after reset set protocol_error; the CFU must be reset alongside this block.

Optional Feature:
- Macro: CFU_ROB_BYPASS_EN.
- Defined: when a legal response targets slot head, the buffer is not empty, and filled[head]=0, core_resp_* is driven combinationally from cfu_resp_* in the same cycle (0-cycle latency).
  - If the core accepts, the slot retires without setting filled.
  - If the core does not accept, the response is stored as normal.
- Undefined: 1-cycle capture-to-retire latency always; no combinational path from cfu_resp to core_resp.

Test Plan:
- In-order baseline: issue 3 requests (tags 0,1,2); CFU returns 0,1,2 with data 0x10,0x11,0x12 -> core receives 0x10,0x11,0x12 in order, each 1 cycle after capture, ok=1.
- Reorder: issue tags 0..3; CFU returns 3,1,2,0 with data 0xA3,0xA1,0xA2,0xA0 -> core_resp_valid stays 0 until tag 0 is captured, then 0xA0,0xA1,0xA2,0xA3 on consecutive cycles with core_resp_ready=1.
- Full/wrap:
  - Issue 8 requests (DEPTH=8) -> 9th core_req_ready=0.
  - Retire one -> next cycle issue accepted with cfu_req_id=0 (wrap).
  - Run 20 more requests -> no loss.
- Error propagation and backpressure: tag 0 returns ok=0, error_id=0x5 while core_resp_ready=0 for 4 cycles -> core_resp_valid held with ok=0, error_id=0x5 and stable payload until accepted.
- Protocol error: response with tag 5 when only tags 0-1 are allocated -> protocol_error=1 (sticky), no core response, subsequent legal traffic is unaffected; reset -> protocol_error=0, empty.
- clock_en/reset: clock_en=0 for 3 cycles with requests pending -> no handshakes, state frozen. Reset asserted with 4 outstanding -> empty afterwards, core_resp_valid=0, first new request gets tag 0.

Source files
------------

// File: rtl/cfu_reorder_buffer.sv
// Reorder buffer between an in-order core and a CFU that may answer out of order.
// Optional macro CFU_ROB_BYPASS_EN adds a same-cycle response path to the head slot.
module cfu_reorder_buffer #(
  parameter int unsigned CFU_FUNCTION_ID_W = 16,
  parameter int unsigned CFU_REQ_INPUTS    = 2,
  parameter int unsigned CFU_REQ_DATA_W    = 32,
  parameter int unsigned CFU_RESP_DATA_W   = 32,
  parameter int unsigned CFU_ERROR_ID_W    = 32,
  parameter int unsigned CFU_REQ_RESP_ID_W = 3
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      clock_en,
  input  logic                                      core_req_valid,
  output logic                                      core_req_ready,
  input  logic [CFU_FUNCTION_ID_W-1:0]              core_req_function_id,
  input  logic [CFU_REQ_INPUTS*CFU_REQ_DATA_W-1:0]  core_req_data,
  output logic                                      cfu_req_valid,
  input  logic                                      cfu_req_ready,
  output logic [CFU_FUNCTION_ID_W-1:0]              cfu_req_function_id,
  output logic [CFU_REQ_RESP_ID_W-1:0]              cfu_req_id,
  output logic [CFU_REQ_INPUTS*CFU_REQ_DATA_W-1:0]  cfu_req_data,
  input  logic                                      cfu_resp_valid,
  output logic                                      cfu_resp_ready,
  input  logic [CFU_REQ_RESP_ID_W-1:0]              cfu_resp_id,
  input  logic [CFU_RESP_DATA_W-1:0]                cfu_resp_data,
  input  logic                                      cfu_resp_ok,
  input  logic [CFU_ERROR_ID_W-1:0]                 cfu_resp_error_id,
  output logic                                      core_resp_valid,
  input  logic                                      core_resp_ready,
  output logic [CFU_RESP_DATA_W-1:0]                core_resp_data,
  output logic                                      core_resp_ok,
  output logic [CFU_ERROR_ID_W-1:0]                 core_resp_error_id,
  output logic                                      protocol_error
);

  localparam int unsigned ID_W  = CFU_REQ_RESP_ID_W;
  localparam int unsigned DEPTH = 2 ** ID_W;

  logic [ID_W:0]                head_q, tail_q;
  logic [DEPTH-1:0]             alloc_q, filled_q;
  logic                         protocol_error_q;
  logic [CFU_RESP_DATA_W-1:0]   data_q [DEPTH];
  logic [DEPTH-1:0]             ok_q;
  logic [CFU_ERROR_ID_W-1:0]    err_q [DEPTH];

  logic [ID_W-1:0] head_idx, tail_idx;
  logic active, empty, full;
  logic issue_fire, resp_fire, resp_legal, capture, bypass, retire, store;

  assign head_idx = head_q[ID_W-1:0];
  assign tail_idx = tail_q[ID_W-1:0];
  assign active   = clock_en & ~reset;
  assign empty    = (head_q == tail_q);
  assign full     = (head_idx == tail_idx) & (head_q[ID_W] != tail_q[ID_W]);

  // Issue path: full is evaluated on current state, so a same-cycle retire never unblocks issue.
  assign cfu_req_valid       = active & core_req_valid & ~full;
  assign core_req_ready      = active & cfu_req_ready & ~full;
  assign cfu_req_id          = tail_idx;
  assign cfu_req_function_id = core_req_function_id;
  assign cfu_req_data        = core_req_data;
  assign issue_fire          = cfu_req_valid & cfu_req_ready;

  // Slots are reserved at issue time, so responses are never backpressured.
  assign cfu_resp_ready = active;
  assign resp_fire      = cfu_resp_valid & cfu_resp_ready;
  assign resp_legal     = alloc_q[cfu_resp_id] & ~filled_q[cfu_resp_id];
  assign capture        = resp_fire & resp_legal;

`ifdef CFU_ROB_BYPASS_EN
  assign bypass = capture & ~empty & (cfu_resp_id == head_idx);
`else
  assign bypass = 1'b0;
`endif

  assign core_resp_valid = (active & ~empty & filled_q[head_idx]) | bypass;
  assign retire          = core_resp_valid & core_resp_ready;
  assign store           = capture & ~(bypass & retire);
  assign protocol_error  = protocol_error_q;

  always_comb begin
    core_resp_data     = data_q[head_idx];
    core_resp_ok       = ok_q[head_idx];
    core_resp_error_id = err_q[head_idx];
`ifdef CFU_ROB_BYPASS_EN
    if (bypass) begin
      core_resp_data     = cfu_resp_data;
      core_resp_ok       = cfu_resp_ok;
      core_resp_error_id = cfu_resp_error_id;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q           <= '0;
      tail_q           <= '0;
      alloc_q          <= '0;
      filled_q         <= '0;
      protocol_error_q <= 1'b0;
    end else begin
      if (issue_fire) begin
        alloc_q[tail_idx] <= 1'b1;
        tail_q            <= tail_q + 1'b1;
      end
      if (store) begin
        filled_q[cfu_resp_id] <= 1'b1;
      end
      if (resp_fire && !resp_legal) begin
        protocol_error_q <= 1'b1;
      end
      // Retire targets the head slot, which never collides with the issue or store above.
      if (retire) begin
        alloc_q[head_idx]  <= 1'b0;
        filled_q[head_idx] <= 1'b0;
        head_q             <= head_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (store) begin
      data_q[cfu_resp_id] <= cfu_resp_data;
      ok_q[cfu_resp_id]   <= cfu_resp_ok;
      err_q[cfu_resp_id]  <= cfu_resp_error_id;
    end
  end

endmodule

// File: tb/tb_cfu_reorder_buffer.sv
// Self-checking bench: directed scenarios plus random traffic against an issue-order queue model.
module tb_cfu_reorder_buffer;

  localparam int FW = 16, NIN = 2, DW = 32, RW = 32, EW = 32, IW = 3, DEPTH = 8;

  logic clock = 1'b0, reset = 1'b1, clock_en = 1'b0;
  logic core_req_valid = 1'b0, core_req_ready;
  logic [FW-1:0] core_req_function_id = '0;
  logic [NIN*DW-1:0] core_req_data = '0;
  logic cfu_req_valid, cfu_req_ready = 1'b0;
  logic [FW-1:0] cfu_req_function_id;
  logic [IW-1:0] cfu_req_id;
  logic [NIN*DW-1:0] cfu_req_data;
  logic cfu_resp_valid = 1'b0, cfu_resp_ready;
  logic [IW-1:0] cfu_resp_id = '0;
  logic [RW-1:0] cfu_resp_data = '0;
  logic cfu_resp_ok = 1'b0;
  logic [EW-1:0] cfu_resp_error_id = '0;
  logic core_resp_valid, core_resp_ready = 1'b0;
  logic [RW-1:0] core_resp_data;
  logic core_resp_ok;
  logic [EW-1:0] core_resp_error_id;
  logic protocol_error;

  always #5 clock = ~clock;

  cfu_reorder_buffer #(
    .CFU_FUNCTION_ID_W(FW), .CFU_REQ_INPUTS(NIN), .CFU_REQ_DATA_W(DW),
    .CFU_RESP_DATA_W(RW), .CFU_ERROR_ID_W(EW), .CFU_REQ_RESP_ID_W(IW)
  ) dut (
    .clock(clock), .reset(reset), .clock_en(clock_en),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_function_id(core_req_function_id), .core_req_data(core_req_data),
    .cfu_req_valid(cfu_req_valid), .cfu_req_ready(cfu_req_ready),
    .cfu_req_function_id(cfu_req_function_id), .cfu_req_id(cfu_req_id),
    .cfu_req_data(cfu_req_data),
    .cfu_resp_valid(cfu_resp_valid), .cfu_resp_ready(cfu_resp_ready),
    .cfu_resp_id(cfu_resp_id), .cfu_resp_data(cfu_resp_data), .cfu_resp_ok(cfu_resp_ok),
    .cfu_resp_error_id(cfu_resp_error_id),
    .core_resp_valid(core_resp_valid), .core_resp_ready(core_resp_ready),
    .core_resp_data(core_resp_data), .core_resp_ok(core_resp_ok),
    .core_resp_error_id(core_resp_error_id), .protocol_error(protocol_error)
  );

  typedef struct {
    int            tag;
    bit            filled;
    logic [RW-1:0] data;
    bit            ok;
    logic [EW-1:0] err;
  } ent_t;

  ent_t ob[$];  // outstanding requests, oldest first
  int   next_tag = 0;
  bit   perr = 1'b0;
  int   errors = 0, checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int find_tag(input int t);
    foreach (ob[i]) if (ob[i].tag == t) return i;
    return -1;
  endfunction

  function automatic int pick_unfilled();
    int c[$];
    foreach (ob[i]) if (!ob[i].filled) c.push_back(ob[i].tag);
    if (c.size() == 0) return -1;
    return c[$urandom_range(c.size() - 1)];
  endfunction

  function automatic int pick_illegal();
    int c[$];
    int i;
    for (int t = 0; t < DEPTH; t++) begin
      i = find_tag(t);
      if (i < 0 || ob[i].filled) c.push_back(t);
    end
    if (c.size() == 0) return -1;
    return c[$urandom_range(c.size() - 1)];
  endfunction

  // Called just after a falling edge with inputs already driven; checks, then advances the model.
  task automatic tick();
    bit ce, full, empty, e_rqv, e_rqr, rfire, legal, e_rsv, byp, issue, retire;
    int idx;
    logic [RW-1:0] e_d;
    bit e_ok;
    logic [EW-1:0] e_err;
    ent_t e;
    #1;
    ce    = clock_en && !reset;
    full  = (ob.size() == DEPTH);
    empty = (ob.size() == 0);
    e_rqv = ce && core_req_valid && !full;
    e_rqr = ce && cfu_req_ready && !full;
    rfire = ce && cfu_resp_valid;
    idx   = find_tag(int'(cfu_resp_id));
    legal = 1'b0;
    if (idx >= 0) legal = !ob[idx].filled;
    e_rsv = 1'b0;
    if (ce && !empty) e_rsv = ob[0].filled;
    byp = 1'b0;
`ifdef CFU_ROB_BYPASS_EN
    byp = rfire && legal && (idx == 0);
`endif
    e_d = '0; e_ok = 1'b0; e_err = '0;
    if (e_rsv) begin
      e_d = ob[0].data; e_ok = ob[0].ok; e_err = ob[0].err;
    end else if (byp) begin
      e_d = cfu_resp_data; e_ok = cfu_resp_ok; e_err = cfu_resp_error_id;
    end
    check("cfu_req_valid", 64'(cfu_req_valid), 64'(e_rqv));
    check("core_req_ready", 64'(core_req_ready), 64'(e_rqr));
    check("cfu_resp_ready", 64'(cfu_resp_ready), 64'(ce));
    check("core_resp_valid", 64'(core_resp_valid), 64'(e_rsv || byp));
    check("protocol_error", 64'(protocol_error), 64'(perr));
    if (e_rqv) begin
      check("cfu_req_id", 64'(cfu_req_id), 64'(next_tag));
      check("cfu_req_function_id", 64'(cfu_req_function_id), 64'(core_req_function_id));
      check("cfu_req_data", 64'(cfu_req_data), 64'(core_req_data));
    end
    if (e_rsv || byp) begin
      check("core_resp_data", 64'(core_resp_data), 64'(e_d));
      check("core_resp_ok", 64'(core_resp_ok), 64'(e_ok));
      check("core_resp_error_id", 64'(core_resp_error_id), 64'(e_err));
    end
    issue  = e_rqv && cfu_req_ready;
    retire = (e_rsv || byp) && core_resp_ready;
    e.tag = next_tag; e.filled = 1'b0; e.data = '0; e.ok = 1'b0; e.err = '0;
    @(posedge clock);
    if (reset) begin
      ob.delete();
      next_tag = 0;
      perr = 1'b0;
    end else begin
      if (rfire) begin
        if (!legal) perr = 1'b1;
        else if (!(byp && retire)) begin
          ob[idx].filled = 1'b1;
          ob[idx].data   = cfu_resp_data;
          ob[idx].ok     = cfu_resp_ok;
          ob[idx].err    = cfu_resp_error_id;
        end
      end
      if (retire) void'(ob.pop_front());
      if (issue) begin
        ob.push_back(e);
        next_tag = (next_tag + 1) % DEPTH;
      end
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    clock_en = 1'b1; core_req_valid = 1'b0; cfu_resp_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_reset();
    reset = 1'b1; core_req_valid = 1'b0; cfu_resp_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic req(input int n);
    for (int i = 0; i < n; i++) begin
      core_req_valid = 1'b1;
      core_req_function_id = FW'($urandom);
      core_req_data = {$urandom, $urandom};
      tick();
    end
    core_req_valid = 1'b0;
  endtask

  task automatic resp(input int tag, input logic [RW-1:0] d, input bit ok, input logic [EW-1:0] er);
    cfu_resp_valid = 1'b1; cfu_resp_id = IW'(tag);
    cfu_resp_data = d; cfu_resp_ok = ok; cfu_resp_error_id = er;
    tick();
    cfu_resp_valid = 1'b0;
  endtask

  initial begin
    int t;
    // Let the first reset edge settle unknown state before checking anything.
    cfu_req_ready = 1'b1; core_resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    tick();
    reset = 1'b0;
    clock_en = 1'b1;

    // In-order baseline.
    req(3);
    resp(0, 32'h10, 1'b1, '0);
    resp(1, 32'h11, 1'b1, '0);
    resp(2, 32'h12, 1'b1, '0);
    idle(3);

    // Reordered responses.
    pulse_reset();
    req(4);
    resp(3, 32'hA3, 1'b1, '0);
    resp(1, 32'hA1, 1'b1, '0);
    resp(2, 32'hA2, 1'b1, '0);
    resp(0, 32'hA0, 1'b1, '0);
    idle(6);

    // Full, retire-then-issue wrap, then sustained traffic.
    pulse_reset();
    req(9);
    resp(0, 32'hB0, 1'b1, '0);
    core_req_valid = 1'b1;
    tick();
    req(1);
    for (int i = 0; i < 20; i++) begin
      t = pick_unfilled();
      cfu_resp_valid = (t >= 0);
      cfu_resp_id = IW'(t); cfu_resp_data = $urandom; cfu_resp_ok = 1'b1;
      req(1);
    end
    cfu_resp_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      t = pick_unfilled();
      if (t >= 0) resp(t, $urandom, 1'b1, '0);
      else idle(1);
    end

    // Error response held under backpressure.
    pulse_reset();
    req(1);
    core_resp_ready = 1'b0;
    resp(0, 32'hDEAD, 1'b0, 32'h5);
    idle(4);
    core_resp_ready = 1'b1;
    idle(2);

    // Protocol error, then legal traffic, then reset clears it.
    pulse_reset();
    req(2);
    resp(5, 32'h55, 1'b1, '0);
    resp(0, 32'hC0, 1'b1, '0);
    resp(1, 32'hC1, 1'b1, '0);
    idle(3);
    pulse_reset();
    idle(1);

    // clock_en low freezes everything; reset drops outstanding entries.
    req(4);
    clock_en = 1'b0; core_req_valid = 1'b1; cfu_resp_valid = 1'b1;
    cfu_resp_id = 3'd0; cfu_resp_data = 32'hF0; cfu_resp_ok = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    clock_en = 1'b1; core_req_valid = 1'b0; cfu_resp_valid = 1'b0;
    pulse_reset();
    idle(1);
    req(1);
    idle(1);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(499) == 0);
      clock_en = ($urandom_range(9) != 0);
      core_req_valid = ($urandom_range(9) < 6);
      core_req_function_id = FW'($urandom);
      core_req_data = {$urandom, $urandom};
      cfu_req_ready = ($urandom_range(9) < 8);
      core_resp_ready = ($urandom_range(9) < 7);
      t = -1;
      if ($urandom_range(1) == 1) t = ($urandom_range(39) == 0) ? pick_illegal() : pick_unfilled();
      cfu_resp_valid = (t >= 0);
      cfu_resp_id = IW'(t < 0 ? 0 : t);
      cfu_resp_data = $urandom;
      cfu_resp_ok = $urandom_range(1);
      cfu_resp_error_id = $urandom;
      tick();
    end
    reset = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
